// File: rtl/uart_bus_pkg.sv
// Shared constants and FSM state type for the uart bus master.
package uart_bus_pkg;

    localparam logic [7:0] ADDR_CTRL = 8'd1;
    localparam logic [7:0] ADDR_BUF  = 8'd2;

    localparam int unsigned CTRL_RX_FULL  = 0;
    localparam int unsigned CTRL_TX_EMPTY = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_POLL_WAIT,
        ST_DECIDE,
        ST_RD_RX,
        ST_RX_WAIT,
        ST_WR_TX
    } state_t;

endpackage

// File: rtl/uart_bus_master_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; same-cycle push and pop honoured even when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[AW'(i)] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Polls the uart control register and turns its buffer into TX/RX byte streams.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int unsigned POLL_GAP = 0,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic [7:0]       o_bus_addr,
    output logic [7:0]       o_bus_wdata,
    output logic             o_bus_w_en,
    output logic             o_bus_r_en,
    input  logic [7:0]       i_bus_rdata,
    output logic [CNT_W-1:0] o_tx_bytes,
    output logic [CNT_W-1:0] o_rx_bytes
);

    localparam int unsigned GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    state_t           r_state;
    logic [GAP_W-1:0] r_gap;
    logic [1:0]       r_flags;
    logic [7:0]       r_bus_addr;
    logic [7:0]       r_bus_wdata;
    logic             r_bus_w_en;
    logic             r_bus_r_en;
    logic [CNT_W-1:0] r_tx_bytes;
    logic [CNT_W-1:0] r_rx_bytes;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_rx_push;

    assign w_rx_push = (r_state == ST_RX_WAIT);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_wdata (i_bus_rdata),
        .i_pop   (i_rx_ready),
        .o_rdata (o_rx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Bus strobes are set on the transition into their state so they are high exactly for that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gap       <= '0;
            r_flags     <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_w_en  <= 1'b0;
            r_bus_r_en  <= 1'b0;
            r_tx_bytes  <= '0;
            r_rx_bytes  <= '0;
        end else begin
            r_bus_r_en <= 1'b0;
            r_bus_w_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_gap == GAP_W'(POLL_GAP)) begin
                        r_state    <= ST_POLL;
                        r_bus_r_en <= 1'b1;
                        r_bus_addr <= ADDR_CTRL;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                ST_POLL: r_state <= ST_POLL_WAIT;
                ST_POLL_WAIT: begin
                    r_flags <= i_bus_rdata[1:0];
                    r_state <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (r_flags[CTRL_RX_FULL] && !w_fifo_full) begin
                        r_state    <= ST_RD_RX;
                        r_bus_r_en <= 1'b1;
                        r_bus_addr <= ADDR_BUF;
                    end else if (r_flags[CTRL_TX_EMPTY] && i_tx_valid) begin
                        r_state     <= ST_WR_TX;
                        r_bus_w_en  <= 1'b1;
                        r_bus_addr  <= ADDR_BUF;
                        r_bus_wdata <= i_tx_data;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end
                end
                ST_RD_RX: r_state <= ST_RX_WAIT;
                ST_RX_WAIT: begin
                    r_rx_bytes <= r_rx_bytes + CNT_W'(1);
                    r_state    <= ST_IDLE;
                    r_gap      <= '0;
                end
                ST_WR_TX: begin
                    r_tx_bytes <= r_tx_bytes + CNT_W'(1);
                    r_state    <= ST_IDLE;
                    r_gap      <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gap   <= '0;
                end
            endcase
        end
    end

    assign o_tx_ready  = (r_state == ST_WR_TX);
    assign o_rx_valid  = !w_fifo_empty;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_w_en  = r_bus_w_en;
    assign o_bus_r_en  = r_bus_r_en;
    assign o_tx_bytes  = r_tx_bytes;
    assign o_rx_bytes  = r_rx_bytes;

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized scoreboard bench for uart_bus_master with a behavioural uart peripheral model.
module tb_uart_bus_master;

    localparam int unsigned POLL_GAP = 0;
    localparam int unsigned RX_DEPTH = 4;
    localparam int unsigned CNT_W    = 16;

    logic             clk;
    logic             rst;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       bus_addr;
    logic [7:0]       bus_wdata;
    logic             bus_w_en;
    logic             bus_r_en;
    logic [7:0]       bus_rdata;
    logic [CNT_W-1:0] tx_bytes;
    logic [CNT_W-1:0] rx_bytes;

    uart_bus_master #(
        .POLL_GAP (POLL_GAP),
        .RX_DEPTH (RX_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tx_data   (tx_data),
        .i_tx_valid  (tx_valid),
        .o_tx_ready  (tx_ready),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .i_rx_ready  (rx_ready),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .o_bus_w_en  (bus_w_en),
        .o_bus_r_en  (bus_r_en),
        .i_bus_rdata (bus_rdata),
        .o_tx_bytes  (tx_bytes),
        .o_rx_bytes  (rx_bytes)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Peripheral model: pending RX bytes in a ring, tx_empty returns busy_len cycles after a write.
    logic [7:0]  inj_mem [256];
    int unsigned inj_wr     = 0;
    int unsigned inj_rd     = 0;
    logic        p_tx_empty = 1'b1;
    int          p_busy     = 0;
    int          busy_len   = 0;

    always @(posedge clk) begin
        if (bus_r_en && bus_addr == 8'd1) begin
            bus_rdata <= {6'b0, p_tx_empty, inj_rd != inj_wr};
        end else if (bus_r_en && bus_addr == 8'd2) begin
            bus_rdata <= inj_mem[inj_rd[7:0]];
            inj_rd    <= inj_rd + 1;
        end else begin
            bus_rdata <= 8'hEE;
        end
        if (bus_w_en && bus_addr == 8'd2) begin
            p_tx_empty <= 1'b0;
            p_busy     <= busy_len;
        end else if (!p_tx_empty) begin
            if (p_busy <= 0) p_tx_empty <= 1'b1;
            else             p_busy     <= p_busy - 1;
        end
    end

    logic [7:0]  exp_tx [$];
    logic [7:0]  exp_rx [$];
    int unsigned n_tx_sent = 0;
    int unsigned n_rx_inj  = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: bus protocol rules and scoreboard pops.
    int unsigned last_poll = 0, last_rd_cyc = 0, last_wr_cyc = 0;
    int unsigned n_polls = 0, n_rd = 0, n_wr = 0, n_pop = 0;
    bit          have_poll = 0, buf_since = 0, prev_hold = 0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            have_poll = 0;
            prev_hold = 0;
            n_rd      = 0;
            n_pop     = 0;
        end else begin
            if (bus_r_en && bus_w_en) chk("rd_wr_overlap", 1, 0);
            if (tx_ready && !bus_w_en) chk("tx_ready_without_write", 1, 0);
            if (bus_r_en && bus_addr == 8'd1) begin
                n_polls++;
                if (have_poll && !buf_since) chk("poll_spacing", cyc - last_poll, POLL_GAP + 4);
                have_poll = 1;
                buf_since = 0;
                last_poll = cyc;
            end
            if (bus_r_en && bus_addr == 8'd2) begin
                chk("rd_poll_dist", have_poll ? cyc - last_poll : 32'hFFFF_FFFF, 3);
                chk("rd_pending", 32'(inj_rd != inj_wr), 1);
                chk("rd_fifo_space", 32'((n_rd - n_pop) < RX_DEPTH), 1);
                n_rd++;
                last_rd_cyc = cyc;
                buf_since   = 1;
            end
            if (bus_w_en) begin
                chk("wr_addr", 32'(bus_addr), 2);
                chk("wr_poll_dist", have_poll ? cyc - last_poll : 32'hFFFF_FFFF, 3);
                chk("wr_tx_ready", 32'(tx_ready), 1);
                chk("wr_periph_empty", 32'(p_tx_empty), 1);
                if (exp_tx.size() == 0) chk("wr_unexpected", 32'(bus_wdata), 32'hFFFF_FFFF);
                else                    chk("wr_data", 32'(bus_wdata), 32'(exp_tx.pop_front()));
                n_wr++;
                last_wr_cyc = cyc;
                buf_since   = 1;
            end
            if (prev_hold && rx_valid) chk("rx_stable", 32'(rx_data), 32'(prev_data));
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                else                    chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                n_pop++;
            end
            prev_hold = rx_valid && !rx_ready;
            prev_data = rx_data;
        end
    end

    // rx_ready driver: 0 = hold off, 1 = always ready, otherwise random.
    int rx_mode = 1;
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rx_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic inject(input logic [7:0] b);
        inj_mem[inj_wr[7:0]] = b;
        inj_wr = inj_wr + 1;
        exp_rx.push_back(b);
        n_rx_inj++;
    endtask

    task automatic send_tx(input logic [7:0] b);
        bit ok = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        exp_tx.push_back(b);
        n_tx_sent++;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("tx_accept");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_drained(input string name);
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_rx.size() == 0 && inj_rd == inj_wr && exp_tx.size() == 0 && !rx_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_addr", 32'(bus_addr), 0);
        chk("rst_bus_wdata", 32'(bus_wdata), 0);
        chk("rst_bus_w_en", 32'(bus_w_en), 0);
        chk("rst_bus_r_en", 32'(bus_r_en), 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_tx_bytes", 32'(tx_bytes), 0);
        chk("rst_rx_bytes", 32'(rx_bytes), 0);
        exp_tx.delete();
        exp_rx.delete();
        n_tx_sent = 0;
        n_rx_inj  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int unsigned polls0, wr0, first_wr;
        bit ok;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        do_reset();

        // Idle polling with tx_empty set and nothing to send.
        polls0 = n_polls;
        wr0    = n_wr;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("idle_polls", 32'((n_polls - polls0) >= 8), 1);
        chk("idle_no_write", n_wr - wr0, 0);
        chk("idle_tx_bytes", 32'(tx_bytes), 0);

        // First byte, then peripheral stays busy for 50 cycles.
        busy_len = 50;
        send_tx(8'hA5);
        first_wr = last_wr_cyc;
        chk("tx_bytes_1", 32'(tx_bytes), 1);
        busy_len = 0;
        send_tx(8'hC3);
        chk("tx_busy_gap", 32'((last_wr_cyc - first_wr) >= 50), 1);
        chk("tx_bytes_2", 32'(tx_bytes), 2);
        repeat (5) @(posedge clk);

        // RX and TX both pending at the same poll: read must win, write on the next poll.
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_r_en && bus_addr == 8'd1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("prio_poll");
        inject(8'h3C);
        send_tx(8'h5A);
        wait_drained("prio_drain");
        chk("prio_wr_after_rd", last_wr_cyc - last_rd_cyc, 6);
        chk("prio_rx_bytes", 32'(rx_bytes), 1);

        // Backpressure: six bytes into a four-deep FIFO with the consumer stalled.
        do_reset();
        rx_mode = 0;
        repeat (2) @(posedge clk);
        for (int b = 1; b <= 6; b++) inject(8'(b));
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("bp_buffered", 32'(rx_bytes), 4);
        chk("bp_pending", inj_wr - inj_rd, 2);
        chk("bp_rx_valid", 32'(rx_valid), 1);
        rx_mode = 1;
        wait_drained("bp_drain");
        chk("bp_rx_bytes", 32'(rx_bytes), 6);

        // Random mix of traffic.
        rx_mode = 2;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) inject(8'($urandom));
            if ($urandom_range(0, 3) == 0) inject(8'($urandom));
            busy_len = $urandom_range(0, 8);
            if ($urandom_range(0, 2) != 0) send_tx(8'($urandom));
            else repeat ($urandom_range(1, 10)) @(posedge clk);
        end
        rx_mode = 1;
        wait_drained("rand_drain");
        chk("rand_tx_bytes", 32'(tx_bytes), n_tx_sent);
        chk("rand_rx_bytes", 32'(rx_bytes), n_rx_inj);

        // Counter wrap.
        busy_len = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        force dut.r_tx_bytes = 16'hFFFF;
        @(negedge clk);
        release dut.r_tx_bytes;
        send_tx(8'h77);
        @(negedge clk);
        chk("tx_wrap", 32'(tx_bytes), 0);

        // Reset while the RX byte is on the bus.
        do_reset();
        inject(8'hFF);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_r_en && bus_addr == 8'd2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("midrst_rd");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rx_valid", 32'(rx_valid), 0);
        chk("midrst_rx_bytes", 32'(rx_bytes), 0);
        chk("midrst_r_en", 32'(bus_r_en), 0);
        chk("midrst_w_en", 32'(bus_w_en), 0);
        exp_rx.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("post_rst_rx_valid", 32'(rx_valid), 0);
        chk("post_rst_rx_bytes", 32'(rx_bytes), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
